// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Receive side of the ECP5 UART. The asynchronous rx_bit pin is brought into
// the 12 MHz clock domain through a two-flop synchroniser and oversampled to
// deserialise 8N1 frames, LSB first. Each good byte is placed in a one-entry
// holding register that the bus side pops with a one-cycle rd strobe.
// Framing errors and overruns are kept as sticky flags that rd clears.
//
// Ports:
//    clk        - 12 MHz reference clock, all logic on the rising edge
//    reset_n    - synchronous, active-low reset
//    rx_bit     - asynchronous serial input, idles high
//    rd         - one-cycle pop of the holding register, also clears flags
//    data_out   - last received byte
//    data_valid - holding register contains an unread byte
//    frame_err  - sticky: a frame ended with a low stop bit
//    overrun    - sticky: a good byte was dropped because the holding
//                 register was still full
//    busy       - receiver is somewhere other than IDLE
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int CLKS_PER_BIT = 104,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx_bit,
   input  logic       rd,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   // Terminal counts: one full bit period, and the half period that moves
   // the sampling point from the start-bit edge to the middle of the bit.
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   state_t           state;
   logic             rx_meta;
   logic             rxs;
   logic [CNT_W-1:0] clk_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;

   // Two-flop synchroniser for the asynchronous pin. Both flops come out of
   // reset high so an idle line is not mistaken for a start bit. Everything
   // downstream looks only at rxs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx_bit;
         rxs     <= rx_meta;
      end
   end

   // Receive state machine plus the holding register and status flags.
   // The rd clears are written first so that any flag or load assigned later
   // in the same cycle overrides them: a set always beats a clear, and a byte
   // landing on the same cycle as rd replaces the byte being popped.
   // After the stop-bit mid-sample the machine goes straight back to IDLE,
   // leaving about half a bit period to spot a back-to-back start bit.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         clk_cnt    <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         if (rd) begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (!rxs) begin
                  state   <= START;
                  clk_cnt <= '0;
                  busy    <= 1'b1;
               end
            end

            START: begin
               if (clk_cnt == HALF_LAST) begin
                  clk_cnt <= '0;
                  if (rxs) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     bit_idx <= '0;
                     state   <= DATA;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            DATA: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt         <= '0;
                  shift[bit_idx]  <= rxs;
                  bit_idx         <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            STOP: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt <= '0;
                  if (rxs) begin
                     if (!data_valid || rd) begin
                        data_out   <= shift;
                        data_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= BREAK;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            BREAK: begin
               if (rxs) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
